// File: rtl/ahb3lite_mem_fill.sv
// AHB3-Lite master that fills a memory region with an incrementing pattern
// or checks a region against that pattern and reports miscompares.
module ahb3lite_mem_fill #(
    parameter int HADDR_SIZE = 32,
    parameter int HDATA_SIZE = 32
) (
    input  logic                  HRESETn,
    input  logic                  HCLK,

    input  logic                  start_i,
    input  logic                  mode_i,
    input  logic [HADDR_SIZE-1:0] base_i,
    input  logic [15:0]           len_i,
    input  logic [HDATA_SIZE-1:0] pattern_i,
    input  logic [HDATA_SIZE-1:0] incr_i,

    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [15:0]           err_cnt_o,
    output logic [HADDR_SIZE-1:0] err_addr_o,

    output logic [HADDR_SIZE-1:0] HADDR,
    output logic [HDATA_SIZE-1:0] HWDATA,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [1:0]            HTRANS,
    output logic                  HMASTLOCK,

    input  logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);

    localparam logic [HADDR_SIZE-1:0] STEP = HADDR_SIZE'(HDATA_SIZE / 8);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_LAST,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        TR_IDLE   = 2'b00,
        TR_BUSY   = 2'b01,
        TR_NONSEQ = 2'b10,
        TR_SEQ    = 2'b11
    } trans_t;

    state_t                  state;
    trans_t                  htrans;
    logic                    mode;
    logic                    abort;
    logic [15:0]             remaining;
    logic [HADDR_SIZE-1:0]   next_addr;
    logic [HDATA_SIZE-1:0]   cur_data;
    logic [HDATA_SIZE-1:0]   next_data;
    logic [HDATA_SIZE-1:0]   incr;
    logic                    dp_valid;
    logic [HADDR_SIZE-1:0]   dp_addr;
    logic [HDATA_SIZE-1:0]   dp_data;
    logic                    bus_err;
    logic                    miscmp;

    assign HTRANS    = htrans;
    assign HSIZE     = (HDATA_SIZE == 64) ? 3'b011 : 3'b010;
    assign HBURST    = 3'b001;
    assign HPROT     = 4'b0011;
    assign HMASTLOCK = 1'b0;

    // Classify the current data phase: first ERROR cycle, or a completed read that miscompares
    always_comb begin
        bus_err = dp_valid & HRESP & ~HREADY;
        miscmp  = dp_valid & HREADY & ~HRESP & mode & (HRDATA != dp_data);
    end

    // Sequencer: address/data pipeline, error tracking and status outputs
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state      <= S_IDLE;
            htrans     <= TR_IDLE;
            mode       <= 1'b0;
            abort      <= 1'b0;
            remaining  <= '0;
            next_addr  <= '0;
            cur_data   <= '0;
            next_data  <= '0;
            incr       <= '0;
            dp_valid   <= 1'b0;
            dp_addr    <= '0;
            dp_data    <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            err_cnt_o  <= '0;
            err_addr_o <= '0;
            HADDR      <= '0;
            HWDATA     <= '0;
            HWRITE     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        mode       <= mode_i;
                        incr       <= incr_i;
                        err_o      <= 1'b0;
                        err_cnt_o  <= '0;
                        err_addr_o <= '0;
                        abort      <= 1'b0;
                        dp_valid   <= 1'b0;
                        busy_o     <= 1'b1;
                        if (len_i == 16'd0) begin
                            state  <= S_DONE;
                            done_o <= 1'b1;
                        end else begin
                            state     <= S_ADDR;
                            HADDR     <= base_i;
                            htrans    <= TR_NONSEQ;
                            HWRITE    <= ~mode_i;
                            cur_data  <= pattern_i;
                            next_data <= pattern_i + incr_i;
                            next_addr <= base_i + STEP;
                            remaining <= len_i - 16'd1;
                        end
                    end
                end

                S_ADDR, S_LAST: begin
                    if (abort) begin
                        // Second ERROR cycle: the slave completes the response, then stop
                        if (HREADY) begin
                            abort    <= 1'b0;
                            dp_valid <= 1'b0;
                            state    <= S_DONE;
                            done_o   <= 1'b1;
                        end
                    end else if (bus_err) begin
                        abort  <= 1'b1;
                        htrans <= TR_IDLE;
                        err_o  <= 1'b1;
                        if (!err_o) err_addr_o <= dp_addr;
                    end else if (HREADY) begin
                        if (miscmp) begin
                            err_o <= 1'b1;
                            if (err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 16'd1;
                            if (!err_o) err_addr_o <= dp_addr;
                        end
                        if (state == S_LAST) begin
                            dp_valid <= 1'b0;
                            state    <= S_DONE;
                            done_o   <= 1'b1;
                        end else begin
                            // Accepted address phase becomes the next data phase
                            dp_valid <= 1'b1;
                            dp_addr  <= HADDR;
                            dp_data  <= cur_data;
                            HWDATA   <= cur_data;
                            if (remaining == 16'd0) begin
                                htrans <= TR_IDLE;
                                state  <= S_LAST;
                            end else begin
                                HADDR     <= next_addr;
                                htrans    <= (next_addr[9:0] == 10'd0) ? TR_NONSEQ : TR_SEQ;
                                cur_data  <= next_data;
                                next_addr <= next_addr + STEP;
                                next_data <= next_data + incr;
                                remaining <= remaining - 16'd1;
                            end
                        end
                    end
                end

                S_DONE: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                    HWRITE <= 1'b0;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb3lite_mem_fill.sv
// Directed bench for ahb3lite_mem_fill with a small SRAM slave model.
module tb_ahb3lite_mem_fill;

    logic        HCLK;
    logic        HRESETn;
    logic        start_i;
    logic        mode_i;
    logic [31:0] base_i;
    logic [15:0] len_i;
    logic [31:0] pattern_i;
    logic [31:0] incr_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [15:0] err_cnt_o;
    logic [31:0] err_addr_o;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
    logic        HMASTLOCK;
    logic [31:0] HRDATA;
    logic        hready;
    logic        hresp;

    int checks;
    int failures;

    ahb3lite_mem_fill #(
        .HADDR_SIZE(32),
        .HDATA_SIZE(32)
    ) dut (
        .HRESETn   (HRESETn),
        .HCLK      (HCLK),
        .start_i   (start_i),
        .mode_i    (mode_i),
        .base_i    (base_i),
        .len_i     (len_i),
        .pattern_i (pattern_i),
        .incr_i    (incr_i),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .err_o     (err_o),
        .err_cnt_o (err_cnt_o),
        .err_addr_o(err_addr_o),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HTRANS    (HTRANS),
        .HMASTLOCK (HMASTLOCK),
        .HRDATA    (HRDATA),
        .HREADY    (hready),
        .HRESP     (hresp)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // SRAM slave: 4 KB window, zero wait states unless the bench drops hready
    logic [31:0] mem [0:1023];
    logic        s_pend;
    logic        s_write;
    logic [9:0]  s_idx;
    logic        poke_req;
    logic [9:0]  poke_idx;
    logic [31:0] poke_data;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            s_pend  <= 1'b0;
            s_write <= 1'b0;
            s_idx   <= '0;
        end else begin
            if (poke_req) mem[poke_idx] <= poke_data;
            if (hready) begin
                if (s_pend && s_write && !hresp) mem[s_idx] <= HWDATA;
                s_pend  <= HTRANS[1];
                s_write <= HWRITE;
                s_idx   <= HADDR[11:2];
            end
        end
    end

    assign HRDATA = s_pend ? mem[s_idx] : 32'h0;

    // Bus monitor, sampled mid-cycle
    logic [1:0]  log_trans [0:127];
    logic [31:0] log_addr  [0:127];
    logic [31:0] log_wd    [0:127];
    int          n_addr;
    int          n_wd;
    int          stall_cnt;
    int          unstable;
    logic        prev_stall;
    logic [31:0] p_addr;
    logic [1:0]  p_trans;
    logic [31:0] p_wd;

    initial begin
        n_addr = 0; n_wd = 0; stall_cnt = 0; unstable = 0; prev_stall = 1'b0;
        p_addr = '0; p_trans = '0; p_wd = '0;
    end

    always @(negedge HCLK) begin
        if (hready && HTRANS != 2'b00 && n_addr < 128) begin
            log_trans[n_addr] = HTRANS;
            log_addr[n_addr]  = HADDR;
            n_addr++;
        end
        if (hready && !hresp && s_pend && s_write && n_wd < 128) begin
            log_wd[n_wd] = HWDATA;
            n_wd++;
        end
        if (!hready && !hresp && busy_o) stall_cnt++;
        if (prev_stall && (HADDR !== p_addr || HTRANS !== p_trans || HWDATA !== p_wd)) unstable++;
        prev_stall = !hready && !hresp && busy_o;
        p_addr     = HADDR;
        p_trans    = HTRANS;
        p_wd       = HWDATA;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #2;
    endtask

    int          op_a0;
    int          op_w0;
    int          op_s0;
    int          op_u0;
    int          done_cyc;
    logic [1:0]  trans_at [0:63];

    // One operation; stall/error windows are cycle numbers counted from start_i
    task automatic run_op(input logic m, input logic [31:0] base, input logic [15:0] len,
                          input logic [31:0] pat, input logic [31:0] inc,
                          input int stall_at, input int stall_n, input int err_at);
        op_a0 = n_addr; op_w0 = n_wd; op_s0 = stall_cnt; op_u0 = unstable;
        start_i = 1'b1; mode_i = m; base_i = base; len_i = len; pattern_i = pat; incr_i = inc;
        tick();
        start_i  = 1'b0;
        done_cyc = -1;
        for (int c = 1; c < 200 && done_cyc < 0; c++) begin
            hready = !(c >= stall_at && c < stall_at + stall_n) && (c != err_at);
            hresp  = (c == err_at) || (c == err_at + 1);
            if (c < 64) trans_at[c] = HTRANS;
            if (done_o) done_cyc = c;
            else tick();
        end
        hready = 1'b1;
        hresp  = 1'b0;
        tick();
    endtask

    task automatic check_ap(input string tag, input int idx, input logic [1:0] tr, input logic [31:0] a);
        check({tag, "_htrans"}, 64'(log_trans[idx]), 64'(tr));
        check({tag, "_haddr"}, 64'(log_addr[idx]), 64'(a));
    endtask

    task automatic check_mem(input string tag, input logic [31:0] a, input logic [31:0] exp);
        check(tag, 64'(mem[a[11:2]]), 64'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0;
        HRESETn = 1'b0; start_i = 1'b0; mode_i = 1'b0; base_i = '0; len_i = '0;
        pattern_i = '0; incr_i = '0; hready = 1'b1; hresp = 1'b0;
        poke_req = 1'b0; poke_idx = '0; poke_data = '0;
        repeat (2) tick();

        check("rst_busy", 64'(busy_o), 64'(0));
        check("rst_done", 64'(done_o), 64'(0));
        check("rst_err", 64'(err_o), 64'(0));
        check("rst_err_cnt", 64'(err_cnt_o), 64'(0));
        check("rst_err_addr", 64'(err_addr_o), 64'(0));
        check("rst_htrans", 64'(HTRANS), 64'(0));
        check("rst_haddr", 64'(HADDR), 64'(0));
        check("rst_hwdata", 64'(HWDATA), 64'(0));
        check("rst_hwrite", 64'(HWRITE), 64'(0));
        check("hsize", 64'(HSIZE), 64'(3'b010));
        check("hburst", 64'(HBURST), 64'(3'b001));
        check("hprot", 64'(HPROT), 64'(4'b0011));
        check("hmastlock", 64'(HMASTLOCK), 64'(0));
        HRESETn = 1'b1;
        tick();

        // Fill 0x100, 4 words
        run_op(1'b0, 32'h100, 16'd4, 32'hA5A5_0000, 32'd1, 0, 0, -10);
        check("fill_done_cycle", 64'(done_cyc), 64'(6));
        check("fill_n_addr", 64'(n_addr - op_a0), 64'(4));
        check_ap("fill_t0", op_a0 + 0, 2'b10, 32'h100);
        check_ap("fill_t1", op_a0 + 1, 2'b11, 32'h104);
        check_ap("fill_t2", op_a0 + 2, 2'b11, 32'h108);
        check_ap("fill_t3", op_a0 + 3, 2'b11, 32'h10C);
        check("fill_n_wd", 64'(n_wd - op_w0), 64'(4));
        for (int k = 0; k < 4; k++)
            check("fill_hwdata", 64'(log_wd[op_w0 + k]), 64'(32'hA5A5_0000 + k));
        check_mem("fill_mem_10c", 32'h10C, 32'hA5A5_0003);
        check("fill_err", 64'(err_o), 64'(0));
        check("fill_idle_busy", 64'(busy_o), 64'(0));

        // Corrupt 0x108, then check the region
        poke_req = 1'b1; poke_idx = 10'h042; poke_data = 32'hDEAD_BEEF;
        tick();
        poke_req = 1'b0;
        run_op(1'b1, 32'h100, 16'd4, 32'hA5A5_0000, 32'd1, 0, 0, -10);
        check("chk_done_cycle", 64'(done_cyc), 64'(6));
        check("chk_err", 64'(err_o), 64'(1));
        check("chk_err_cnt", 64'(err_cnt_o), 64'(1));
        check("chk_err_addr", 64'(err_addr_o), 64'(32'h108));
        check("chk_no_writes", 64'(n_wd - op_w0), 64'(0));

        // Check against a wrong pattern: every word miscompares
        run_op(1'b1, 32'h100, 16'd4, 32'h0, 32'd1, 0, 0, -10);
        check("chk4_err_cnt", 64'(err_cnt_o), 64'(4));
        check("chk4_err_addr", 64'(err_addr_o), 64'(32'h100));

        // 1 KB boundary crossing
        run_op(1'b0, 32'h3F8, 16'd4, 32'h0, 32'h11, 0, 0, -10);
        check_ap("kb_t0", op_a0 + 0, 2'b10, 32'h3F8);
        check_ap("kb_t1", op_a0 + 1, 2'b11, 32'h3FC);
        check_ap("kb_t2", op_a0 + 2, 2'b10, 32'h400);
        check_ap("kb_t3", op_a0 + 3, 2'b11, 32'h404);
        check_mem("kb_mem_404", 32'h404, 32'h33);

        // Three wait states in the second data phase
        run_op(1'b0, 32'h200, 16'd4, 32'h1234_0000, 32'h10, 3, 3, -10);
        check("wait_done_cycle", 64'(done_cyc), 64'(9));
        check("wait_stalls", 64'(stall_cnt - op_s0), 64'(3));
        check("wait_stable", 64'(unstable - op_u0), 64'(0));
        check_mem("wait_mem_200", 32'h200, 32'h1234_0000);
        check_mem("wait_mem_204", 32'h204, 32'h1234_0010);
        check_mem("wait_mem_208", 32'h208, 32'h1234_0020);
        check_mem("wait_mem_20c", 32'h20C, 32'h1234_0030);

        // Zero-length operation
        run_op(1'b0, 32'h300, 16'd0, 32'h0, 32'h1, 0, 0, -10);
        check("len0_done_cycle", 64'(done_cyc), 64'(1));
        check("len0_no_transfers", 64'(n_addr - op_a0), 64'(0));

        // ERROR response on the second transfer
        run_op(1'b0, 32'h500, 16'd4, 32'h77, 32'h1, 0, 0, 3);
        check("berr_done_cycle", 64'(done_cyc), 64'(5));
        check("berr_htrans_held", 64'(trans_at[3]), 64'(2'b11));
        check("berr_htrans_idle", 64'(trans_at[4]), 64'(2'b00));
        check("berr_n_addr", 64'(n_addr - op_a0), 64'(2));
        check("berr_err", 64'(err_o), 64'(1));
        check("berr_err_addr", 64'(err_addr_o), 64'(32'h504));
        check("berr_err_cnt", 64'(err_cnt_o), 64'(0));
        check_mem("berr_mem_500", 32'h500, 32'h77);

        // Reset in the middle of an operation
        start_i = 1'b1; mode_i = 1'b0; base_i = 32'h600; len_i = 16'd8;
        pattern_i = 32'h0; incr_i = 32'h1;
        tick();
        start_i = 1'b0;
        tick();
        check("mid_busy_before", 64'(busy_o), 64'(1));
        HRESETn = 1'b0;
        #1;
        check("mid_rst_htrans", 64'(HTRANS), 64'(0));
        check("mid_rst_busy", 64'(busy_o), 64'(0));
        tick();
        check("mid_rst_haddr", 64'(HADDR), 64'(0));
        check("mid_rst_hwdata", 64'(HWDATA), 64'(0));
        HRESETn = 1'b1;
        tick();
        run_op(1'b0, 32'h700, 16'd2, 32'h55, 32'h1, 0, 0, -10);
        check("post_rst_done_cycle", 64'(done_cyc), 64'(4));
        check_ap("post_rst_t0", op_a0, 2'b10, 32'h700);
        check_mem("post_rst_mem_700", 32'h700, 32'h55);
        check_mem("post_rst_mem_704", 32'h704, 32'h56);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahb3lite_mem_fill.md
AHB3LITE_MEM_FILL -- requirements
Module: ahb3lite_mem_fill

Interface
REQ-001 Parameters: HADDR_SIZE, default 32, address bus width; HDATA_SIZE, default 32, data bus width (32 or 64).
REQ-002 HRESETn  in  1  reset, asynchronous, active-low; HCLK  in  1  clock, rising edge.
REQ-003 start_i  in  1  one-cycle request to begin an operation; mode_i  in  1  0 = fill, 1 = check.
REQ-004 base_i  in  HADDR_SIZE  start byte address, word aligned; len_i  in  16  number of words.
REQ-005 pattern_i  in  HDATA_SIZE  first data word; incr_i  in  HDATA_SIZE  added to the pattern per word.
REQ-006 busy_o  out  1  operation in progress; done_o  out  1  one-cycle completion pulse.
REQ-007 err_o  out  1  sticky miscompare/bus error flag; err_cnt_o  out  16  miscompare count; err_addr_o  out  HADDR_SIZE  first failing address.
REQ-008 AHB3-Lite master outputs: HADDR, HWDATA, HWRITE, HSIZE[2:0], HBURST[2:0], HPROT[3:0], HTRANS[1:0], HMASTLOCK.
REQ-009 AHB3-Lite master inputs: HRDATA[HDATA_SIZE], HREADY, HRESP.

Function
REQ-010 States: IDLE, ADDR (address phase issuing, previous data phase possibly active), LAST (final data phase only), DONE.
REQ-011 IDLE: start_i=1 latches base, len, pattern, incr and mode, and clears err_o, err_cnt_o and err_addr_o; next state is ADDR, or DONE when len_i=0 (no bus transfer).
REQ-012 start_i while busy_o=1 is ignored.
REQ-013 busy_o=1 in ADDR, LAST and DONE; done_o=1 only in DONE; DONE always returns to IDLE after one cycle.
REQ-014 Fixed outputs: HSIZE = WORD (32-bit) or DWORD (64-bit) matching HDATA_SIZE; HBURST=INCR; HPROT=4'b0011; HMASTLOCK=0; HWRITE = ~mode for the whole operation.
REQ-015 Transfer k (0..len-1) uses address base + k*(HDATA_SIZE/8) and expected data pattern + k*incr (modulo 2^HDATA_SIZE).
REQ-016 HTRANS: NONSEQ for transfer 0 and for any transfer whose address is 1 KB aligned; SEQ otherwise; IDLE in IDLE, LAST and DONE.
REQ-017 The address phase advances only when HREADY=1; while HREADY=0, HADDR, HTRANS and HWDATA are held stable.
REQ-018 Fill mode: HWDATA carries the data of transfer k during its data phase, i.e. one cycle after its address phase is accepted.
REQ-019 Check mode: HRDATA is sampled in the data phase of transfer k on HREADY=1 and compared with the expected data.
REQ-020 On a miscompare, err_o is set and err_cnt_o incremented, saturating at 16'hFFFF; err_addr_o is loaded only on the first error of the operation.
REQ-021 The address phase of the last transfer being accepted moves ADDR to LAST; LAST to DONE occurs on HREADY=1.
REQ-022 HRESP=ERROR with HREADY=0 (first error cycle): HTRANS shall be IDLE in the next cycle; err_o is set, err_addr_o is captured if first, no further transfers are issued, and the state goes to DONE after the second error cycle.
REQ-023 Steady-state throughput with HREADY=1 is one word per cycle; operation latency is len+2 cycles from start_i to done_o.
REQ-024 Address arithmetic wraps modulo 2^HADDR_SIZE; no range checking.

Reset
REQ-025 HRESETn low mid-operation aborts immediately; all state is returned to reset values.
REQ-026 Reset values: state IDLE, busy_o=0, done_o=0, err_o=0, err_cnt_o=0, err_addr_o=0, HTRANS=IDLE, HADDR=0, HWDATA=0, HWRITE=0.

Verification
REQ-027 Fill with base=0x100, len=4, pattern=0xA5A5_0000, incr=1, HREADY=1: HTRANS NONSEQ,SEQ,SEQ,SEQ; HWDATA 0xA5A5_0000..0xA5A5_0003; done_o at cycle 6 after start_i.
REQ-028 Check against the SRAM slave after that fill, with one word corrupted at 0x108: err_o=1, err_cnt_o=1, err_addr_o=0x108.
REQ-029 Fill with base=0x3F8, len=4 (32-bit): NONSEQ at 0x3F8 and 0x400, SEQ at 0x3FC and 0x404.
REQ-030 HREADY=0 for 3 cycles during the second data phase: HADDR, HTRANS and HWDATA stay stable; all 4 words are written correctly.
REQ-031 len=0: no non-IDLE HTRANS; done_o one cycle after the cycle after start_i. ERROR response on the 2nd transfer: IDLE follows, err_o=1, err_addr_o=base+4, done_o asserted.
REQ-032 HRESETn asserted during ADDR: next edge shows HTRANS=IDLE, busy_o=0, and a new start_i proceeds normally.
